// File: rtl/ledpwm_m.sv
// ledpwm_m: AXI3-slave LED controller, N_CH channels with per-channel PWM duty and shared prescaler.
// Optional feature macro: LEDPWM_BREATHE_EN (CTRL bit1 selects a shared triangle ramp instead of DUTY).
module ledpwm_m #(
  parameter int N_CH   = 8,
  parameter int PWM_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk0,
  input  logic              i_rst,
  input  logic              i_AXI_AWVALID,
  output logic              o_AXI_AWREADY,
  input  logic [11:0]       i_AXI_AWID,
  input  logic [ADDR_W-1:0] i_AXI_AWADDR,
  input  logic [3:0]        i_AXI_AWLEN,
  input  logic              i_AXI_WVALID,
  output logic              o_AXI_WREADY,
  input  logic [31:0]       i_AXI_WDATA,
  input  logic [3:0]        i_AXI_WSTRB,
  input  logic              i_AXI_WLAST,
  output logic              o_AXI_BVALID,
  input  logic              i_AXI_BREADY,
  output logic [11:0]       o_AXI_BID,
  output logic [1:0]        o_AXI_BRESP,
  input  logic              i_AXI_ARVALID,
  output logic              o_AXI_ARREADY,
  input  logic [11:0]       i_AXI_ARID,
  input  logic [ADDR_W-1:0] i_AXI_ARADDR,
  input  logic [3:0]        i_AXI_ARLEN,
  output logic              o_AXI_RVALID,
  input  logic              i_AXI_RREADY,
  output logic [11:0]       o_AXI_RID,
  output logic [31:0]       o_AXI_RDATA,
  output logic [1:0]        o_AXI_RRESP,
  output logic              o_AXI_RLAST,
  output logic [N_CH-1:0]   o_led
);
  // Handshake rule on every channel: a transfer happens on the rising edge where VALID and
  // READY are both high; the VALID side keeps its payload stable until that edge.
  localparam int AW = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY = 2'd0, RESP_SLVERR = 2'd2;
`ifdef LEDPWM_BREATHE_EN
  localparam logic BR_BIT = 1'b1;
`else
  localparam logic BR_BIT = 1'b0;
`endif
  localparam logic [31:0] INFO_VAL = {BR_BIT, 7'd0, 8'(PWM_W), 8'd0, 8'(N_CH)};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                       live_q;
  logic                       ctrl_en_q, breathe;
  logic [15:0]                presc_q, pcnt_q;
  logic [PWM_W-1:0]           cnt_q;
  logic [N_CH-1:0][PWM_W-1:0] duty_q, cmp;
  logic [N_CH-1:0]            led_q;
  logic [31:0]                ctrl_word, merged;
  logic                       tick, reg_wr, presc_wr;

  logic [11:0]   aw_id_q;
  logic [AW-1:0] aw_word_q;
  logic [3:0]    aw_len_q;
  logic [4:0]    beat_q;
  logic [1:0]    bresp_q;
  logic          aw_ready, w_ready, b_valid, aw_hs, w_hs, w_end, wr_ok;
  logic [32:0]   wr_cur, rd_cur;

  logic [11:0]   r_id_q;
  logic [3:0]    rem_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic          ar_ready, r_valid, ar_hs, r_hs, rd_ok;
  logic          unused_bits;

  // Returns {mapped, zero-extended value} for a word address.
  function automatic logic [32:0] reg_val(input logic [AW-1:0] w, input logic [31:0] ctrl_v,
                                          input logic [15:0] presc_v,
                                          input logic [N_CH-1:0][PWM_W-1:0] duty_v);
    logic [32:0] r;
    r = '0;
    if (int'(w) == 0) r = {1'b1, ctrl_v};
    if (int'(w) == 1) r = {1'b1, INFO_VAL};
    if (int'(w) == 2) r = {1'b1, 16'd0, presc_v};
    for (int c = 0; c < N_CH; c++)
      if (int'(w) == 16 + c) r = {1'b1, {(32 - PWM_W){1'b0}}, duty_v[c]};
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  // Holds both READY outputs low until the first edge after reset release.
  always_ff @(posedge i_clk0 or negedge i_rst)
    if (!i_rst) live_q <= 1'b0;
    else        live_q <= 1'b1;

  assign ctrl_word = {30'd0, breathe, ctrl_en_q};

  // ---------------- write channel ----------------
  always_ff @(posedge i_clk0 or negedge i_rst)
    if (!i_rst) w_state <= W_IDLE;
    else        w_state <= w_next;

  always_comb begin
    w_next   = w_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = live_q;
        if (live_q && i_AXI_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (i_AXI_WVALID && w_end) w_next = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (i_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs    = aw_ready && i_AXI_AWVALID;
  assign w_hs     = w_ready && i_AXI_WVALID;
  assign w_end    = i_AXI_WLAST || (beat_q > {1'b0, aw_len_q});
  assign wr_cur   = reg_val(aw_word_q, ctrl_word, presc_q, duty_q);
  assign wr_ok    = (aw_len_q == 4'd0) && wr_cur[32] && (int'(aw_word_q) != 1);
  assign merged   = merge(wr_cur[31:0], i_AXI_WDATA, i_AXI_WSTRB);
  assign reg_wr   = w_hs && w_end && wr_ok;
  assign presc_wr = reg_wr && (int'(aw_word_q) == 2);

  always_ff @(posedge i_clk0 or negedge i_rst)
    if (!i_rst) begin
      aw_id_q   <= '0;
      aw_word_q <= '0;
      aw_len_q  <= '0;
      beat_q    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_id_q   <= i_AXI_AWID;
        aw_word_q <= i_AXI_AWADDR[ADDR_W-1:2];
        aw_len_q  <= i_AXI_AWLEN;
        beat_q    <= '0;
      end
      if (w_hs) begin
        beat_q <= beat_q + 5'd1;
        if (w_end) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end

  // ---------------- register file ----------------
`ifdef LEDPWM_BREATHE_EN
  logic breathe_q;
  assign breathe = breathe_q;
`else
  assign breathe = 1'b0;
`endif

  always_ff @(posedge i_clk0 or negedge i_rst)
    if (!i_rst) begin
      ctrl_en_q <= 1'b0;
`ifdef LEDPWM_BREATHE_EN
      breathe_q <= 1'b0;
`endif
      presc_q   <= '0;
      duty_q    <= '0;
    end else if (reg_wr) begin
      if (int'(aw_word_q) == 0) begin
        ctrl_en_q <= merged[0];
`ifdef LEDPWM_BREATHE_EN
        breathe_q <= merged[1];
`endif
      end
      if (presc_wr) presc_q <= merged[15:0];
      for (int c = 0; c < N_CH; c++)
        if (int'(aw_word_q) == 16 + c) duty_q[c] <= merged[PWM_W-1:0];
    end

  // ---------------- PWM engine ----------------
  assign tick = (pcnt_q == presc_q);

  always_ff @(posedge i_clk0 or negedge i_rst)
    if (!i_rst) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
      led_q  <= '0;
    end else begin
      pcnt_q <= (presc_wr || tick) ? 16'd0 : pcnt_q + 16'd1;
      if (tick) cnt_q <= cnt_q + 1'b1;
      for (int c = 0; c < N_CH; c++) led_q[c] <= ctrl_en_q && (cnt_q < cmp[c]);
    end

`ifdef LEDPWM_BREATHE_EN
  // Triangle ramp advances once per PWM period; each value 0..max appears once per sweep.
  logic [PWM_W-1:0] ramp_q;
  logic             ramp_down_q;

  always_ff @(posedge i_clk0 or negedge i_rst)
    if (!i_rst) begin
      ramp_q      <= '0;
      ramp_down_q <= 1'b0;
    end else if (tick && (cnt_q == '1)) begin
      if (!ramp_down_q) begin
        if (ramp_q == '1) begin ramp_down_q <= 1'b1; ramp_q <= ramp_q - 1'b1; end
        else ramp_q <= ramp_q + 1'b1;
      end else begin
        if (ramp_q == '0) begin ramp_down_q <= 1'b0; ramp_q <= ramp_q + 1'b1; end
        else ramp_q <= ramp_q - 1'b1;
      end
    end

  always_comb
    for (int c = 0; c < N_CH; c++) cmp[c] = breathe ? ramp_q : duty_q[c];
`else
  always_comb
    for (int c = 0; c < N_CH; c++) cmp[c] = duty_q[c];
`endif

  // ---------------- read channel ----------------
  always_ff @(posedge i_clk0 or negedge i_rst)
    if (!i_rst) r_state <= R_IDLE;
    else        r_state <= r_next;

  always_comb begin
    r_next   = r_state;
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready = live_q;
        if (live_q && i_AXI_ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (i_AXI_RREADY && (rem_q == 4'd0)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs  = ar_ready && i_AXI_ARVALID;
  assign r_hs   = r_valid && i_AXI_RREADY;
  assign rd_cur = reg_val(i_AXI_ARADDR[ADDR_W-1:2], ctrl_word, presc_q, duty_q);
  assign rd_ok  = (i_AXI_ARLEN == 4'd0) && rd_cur[32];

  // Read data is captured at the AR handshake and held for the whole burst.
  always_ff @(posedge i_clk0 or negedge i_rst)
    if (!i_rst) begin
      r_id_q  <= '0;
      rem_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      r_id_q  <= i_AXI_ARID;
      rem_q   <= i_AXI_ARLEN;
      rdata_q <= rd_ok ? rd_cur[31:0] : 32'd0;
      rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs && (rem_q != 4'd0)) begin
      rem_q <= rem_q - 4'd1;
    end

  assign o_AXI_AWREADY = aw_ready;
  assign o_AXI_WREADY  = w_ready;
  assign o_AXI_BVALID  = b_valid;
  assign o_AXI_BID     = aw_id_q;
  assign o_AXI_BRESP   = bresp_q;
  assign o_AXI_ARREADY = ar_ready;
  assign o_AXI_RVALID  = r_valid;
  assign o_AXI_RID     = r_id_q;
  assign o_AXI_RDATA   = rdata_q;
  assign o_AXI_RRESP   = rresp_q;
  assign o_AXI_RLAST   = r_valid && (rem_q == 4'd0);
  assign o_led         = led_q;

  assign unused_bits = &{1'b0, merged, i_AXI_AWADDR[1:0], i_AXI_ARADDR[1:0]};
endmodule
